// File: rtl/seq_cla_addsub_if.sv
// Operand/result bundle for the nibble-serial adder/subtractor.
// The master drives the request and the slave returns the registered result.
interface seq_cla_addsub_if #(
  parameter int N_NIB = 4
);
  localparam int W = 4 * N_NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_cla_addsub.sv
// Multi-cycle two's-complement adder/subtractor.
// One 4-bit carry-lookahead slice is reused for each nibble, and the carry is chained through a register.
module seq_cla_addsub #(
  parameter int N_NIB = 4
) (
  input logic            clk,
  input logic            rst,
  seq_cla_addsub_if.slave bus
);
  localparam int W  = 4 * N_NIB;
  localparam int CW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  partial;
  logic [CW-1:0] cnt;
  logic          c;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    p;
  logic [3:0]    g;
  logic [3:0]    carry;
  logic [3:0]    nib_sum;
  logic          grp_p;
  logic          grp_g;
  logic          c_next;
  logic [W-1:0]  next_partial;
  logic          next_ovf;
  int            idx;

  // Lookahead slice: each internal carry is expanded from the slice inputs rather than rippled.
  always_comb begin
    idx          = int'(cnt) * 4;
    nib_a        = a_r[idx +: 4];
    nib_b        = b_r[idx +: 4];
    p            = nib_a ^ nib_b;
    g            = nib_a & nib_b;
    carry[0]     = c;
    carry[1]     = g[0] | (p[0] & c);
    carry[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    carry[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    nib_sum      = p ^ carry;
    grp_p        = &p;
    grp_g        = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    c_next       = grp_g | (grp_p & c);
    next_partial = partial;
    next_partial[idx +: 4] = nib_sum;
    next_ovf     = (a_r[W-1] == b_r[W-1]) && (next_partial[W-1] != a_r[W-1]);
  end

  // Results are written only on the final nibble, so sum/cout/ovf never show partial values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      partial  <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b ^ {W{bus.sub}};
            c        <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          partial <= next_partial;
          c       <= c_next;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.sum  <= next_partial;
            bus.cout <= c_next;
            bus.ovf  <= next_ovf;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
